// File: rtl/parameter_pkg.sv
// rtl/parameter_pkg.sv - shared register-file sizing defaults
package parameter_pkg;

   localparam int DEF_PHY_REGS  = 64;
   localparam int DEF_ARCH_REGS = 32;
   localparam int DEF_PHY_WIDTH = 6;
   localparam int DEF_FL_DEPTH  = DEF_PHY_REGS - DEF_ARCH_REGS;

endpackage

// File: rtl/free_list.sv
// rtl/free_list.sv - speculative physical-register free list with commit rollback
module free_list
   import parameter_pkg::*;
#(
   parameter int PHY_REGS  = DEF_PHY_REGS,
   parameter int ARCH_REGS = DEF_ARCH_REGS,
   parameter int PHY_WIDTH = DEF_PHY_WIDTH,
   parameter int FL_DEPTH  = PHY_REGS - ARCH_REGS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic [1:0]           free_list_valid,
   output logic [PHY_WIDTH-1:0] rd_phy_new_0,
   output logic [PHY_WIDTH-1:0] rd_phy_new_1,
   input  logic [1:0]           commit_valid,
   input  logic [PHY_WIDTH-1:0] commit_phy_old_0,
   input  logic [PHY_WIDTH-1:0] commit_phy_old_1,
   output logic [PHY_WIDTH-1:0] free_count,
   output logic                 free_list_stall
);

   localparam int IDX_W = $clog2(FL_DEPTH);
   localparam int PTR_W = IDX_W + 1;

   typedef logic [PTR_W-1:0] ptr_t;
   typedef logic [IDX_W-1:0] idx_t;

   function automatic logic [1:0] popcount2(input logic [1:0] v);
      return {1'b0, v[0]} + {1'b0, v[1]};
   endfunction

   logic [PHY_WIDTH-1:0] fifo_q [FL_DEPTH];
   logic [PHY_WIDTH-1:0] fifo_d [FL_DEPTH];
   ptr_t spec_head_q, spec_head_d;
   ptr_t commit_head_q, commit_head_d;
   ptr_t tail_q, tail_d;

   ptr_t       count;
   idx_t       rd_idx_0, rd_idx_1;
   idx_t       wr_idx_0, wr_idx_1;
   logic [1:0] alloc_req, alloc_n, rel_n;

   // Read-ahead grants and occupancy, visible to Rename before the allocating edge
   always_comb begin
      count           = tail_q - spec_head_q;
      rd_idx_0        = spec_head_q[IDX_W-1:0];
      rd_idx_1        = rd_idx_0 + idx_t'(1);
      rd_phy_new_0    = fifo_q[rd_idx_0];
      rd_phy_new_1    = free_list_valid[0] ? fifo_q[rd_idx_1] : fifo_q[rd_idx_0];
      free_count      = PHY_WIDTH'(count);
      free_list_stall = (count < ptr_t'(2));
   end

   // Next state: release at tail, allocate at spec_head (clamped to tail), flush rollback
   always_comb begin
      fifo_d    = fifo_q;
      rel_n     = popcount2(commit_valid);
      alloc_req = popcount2(free_list_valid);
      alloc_n   = (ptr_t'(alloc_req) > count) ? count[1:0] : alloc_req;
      wr_idx_0  = tail_q[IDX_W-1:0];
      wr_idx_1  = commit_valid[0] ? wr_idx_0 + idx_t'(1) : wr_idx_0;
      if (commit_valid[0]) begin
         fifo_d[wr_idx_0] = commit_phy_old_0;
      end
      if (commit_valid[1]) begin
         fifo_d[wr_idx_1] = commit_phy_old_1;
      end
      tail_d        = tail_q + ptr_t'(rel_n);
      commit_head_d = commit_head_q + ptr_t'(rel_n);
      spec_head_d   = flush ? commit_head_d : spec_head_q + ptr_t'(alloc_n);
   end

   // State registers; reset reloads the free list with the non-architectural registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < FL_DEPTH; i++) begin
            fifo_q[i] <= PHY_WIDTH'(ARCH_REGS + i);
         end
         spec_head_q   <= '0;
         commit_head_q <= '0;
         tail_q        <= ptr_t'(FL_DEPTH);
      end else begin
         fifo_q        <= fifo_d;
         spec_head_q   <= spec_head_d;
         commit_head_q <= commit_head_d;
         tail_q        <= tail_d;
      end
   end

endmodule

// File: tb/tb_free_list.sv
// tb/tb_free_list.sv - scoreboard bench for free_list
module tb_free_list;

   localparam int W = 6;

   logic         clk;
   logic         rst;
   logic         flush;
   logic [1:0]   free_list_valid;
   logic [W-1:0] rd_phy_new_0;
   logic [W-1:0] rd_phy_new_1;
   logic [1:0]   commit_valid;
   logic [W-1:0] commit_phy_old_0;
   logic [W-1:0] commit_phy_old_1;
   logic [W-1:0] free_count;
   logic         free_list_stall;

   free_list dut (
      .clk              (clk),
      .rst              (rst),
      .flush            (flush),
      .free_list_valid  (free_list_valid),
      .rd_phy_new_0     (rd_phy_new_0),
      .rd_phy_new_1     (rd_phy_new_1),
      .commit_valid     (commit_valid),
      .commit_phy_old_0 (commit_phy_old_0),
      .commit_phy_old_1 (commit_phy_old_1),
      .free_count       (free_count),
      .free_list_stall  (free_list_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int cnt;
      int rd0;
   } st_t;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] g_q [$];
   st_t          st_q [$];
   st_t          s;
   logic         chk  = 1'b0;
   logic         gchk = 1'b1;

   // Reference model: m_all holds commit_head..tail, first m_ns entries are in flight;
   // m_map holds the registers currently holding committed architectural state.
   logic [W-1:0] m_all [$];
   logic [W-1:0] m_map [$];
   int           m_ns;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_all.delete();
      m_map.delete();
      m_ns = 0;
      for (int i = 0; i < 32; i++) begin
         m_all.push_back(W'(32 + i));
         m_map.push_back(W'(i));
      end
   endtask

   task automatic model_commit(input logic [W-1:0] old);
      logic [W-1:0] done_reg;
      for (int k = 0; k < m_map.size(); k++) begin
         if (m_map[k] == old) begin
            m_map.delete(k);
            break;
         end
      end
      done_reg = m_all.pop_front();
      m_map.push_back(done_reg);
      m_all.push_back(old);
   endtask

   task automatic cyc(input logic [1:0] v, input logic [1:0] cv,
                      input logic [W-1:0] o0, input logic [W-1:0] o1, input logic f);
      int a;
      int c;
      @(posedge clk);
      #1;
      free_list_valid  = v;
      commit_valid     = cv;
      commit_phy_old_0 = o0;
      commit_phy_old_1 = o1;
      flush            = f;
      chk              = 1'b0;
      gchk             = 1'b1;
      if (v[0]) g_q.push_back(m_all[m_ns]);
      if (v[1]) g_q.push_back(v[0] ? m_all[m_ns + 1] : m_all[m_ns]);
      a = int'(v[0]) + int'(v[1]);
      c = int'(cv[0]) + int'(cv[1]);
      if (cv[0]) model_commit(o0);
      if (cv[1]) model_commit(o1);
      m_ns = f ? 0 : m_ns + a - c;
   endtask

   task automatic check_idle(input int cnt, input int rd0);
      st_t e;
      @(posedge clk);
      #1;
      free_list_valid = 2'b00;
      commit_valid    = 2'b00;
      flush           = 1'b0;
      gchk            = 1'b1;
      chk             = 1'b1;
      e.cnt = cnt;
      e.rd0 = rd0;
      st_q.push_back(e);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      free_list_valid = 2'b00;
      commit_valid    = 2'b00;
      flush           = 1'b0;
      chk             = 1'b0;
      #3 rst = 1'b0;
      #2 rst = 1'b1;
      model_reset();
   endtask

   task automatic grant_chk(input string name, input logic [W-1:0] act);
      logic [W-1:0] e;
      int dup;
      if (g_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s actual=%0d required=queued_grant", name, act);
      end else begin
         e = g_q.pop_front();
         cmp(name, act, e);
         dup = 0;
         foreach (m_map[k]) if (m_map[k] == act) dup = 1;
         cmp({name, "_unique"}, dup, 0);
      end
   endtask

   // Monitor: compares presented grants and requested status samples off the active edge
   always @(negedge clk) begin
      if (rst) begin
         if (gchk && free_list_valid[0]) grant_chk("grant0", rd_phy_new_0);
         if (gchk && free_list_valid[1]) grant_chk("grant1", rd_phy_new_1);
         if (chk) begin
            if (st_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL status_queue actual=empty required=entry");
            end else begin
               s = st_q.pop_front();
               cmp("free_count", free_count, s.cnt);
               cmp("stall", free_list_stall, (s.cnt < 2) ? 1 : 0);
               cmp("rd_phy_new_0", rd_phy_new_0, s.rd0);
               cmp("rd_phy_new_1_idle", rd_phy_new_1, s.rd0);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   int           amax, cmax, a, c, k0, k1;
   logic [1:0]   v, cv;
   logic         f;

   initial begin
      rst              = 1'b0;
      flush            = 1'b0;
      free_list_valid  = 2'b00;
      commit_valid     = 2'b00;
      commit_phy_old_0 = '0;
      commit_phy_old_1 = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      check_idle(32, 32);
      cyc(2'b11, 2'b00, 0, 0, 0);
      check_idle(30, 34);
      for (int i = 0; i < 14; i++) cyc(2'b11, 2'b00, 0, 0, 0);
      check_idle(2, 62);
      cyc(2'b11, 2'b00, 0, 0, 0);
      check_idle(0, 32);
      @(posedge clk);
      #1;
      free_list_valid = 2'b11;
      chk             = 1'b0;
      gchk            = 1'b0;
      check_idle(0, 32);

      do_reset();
      check_idle(32, 32);
      cyc(2'b11, 2'b00, 0, 0, 0);
      cyc(2'b11, 2'b00, 0, 0, 0);
      cyc(2'b00, 2'b01, 5, 0, 0);
      cyc(2'b00, 2'b00, 0, 0, 1);
      check_idle(32, 33);

      do_reset();
      check_idle(32, 32);
      cyc(2'b10, 2'b00, 0, 0, 0);
      check_idle(31, 33);
      cyc(2'b11, 2'b00, 0, 0, 0);
      check_idle(29, 35);
      cyc(2'b11, 2'b11, 7, 9, 0);
      check_idle(29, 37);
      cyc(2'b00, 2'b00, 0, 0, 1);
      check_idle(32, 34);
      for (int i = 0; i < 15; i++) cyc(2'b11, 2'b00, 0, 0, 0);
      check_idle(2, 7);
      cyc(2'b11, 2'b00, 0, 0, 0);
      check_idle(0, 34);

      for (int n = 0; n < 600; n++) begin
         amax = (32 - m_ns) < 2 ? 32 - m_ns : 2;
         cmax = m_ns < 2 ? m_ns : 2;
         a = $urandom_range(0, amax);
         c = $urandom_range(0, cmax);
         v  = (a == 2) ? 2'b11 : (a == 1) ? (($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10) : 2'b00;
         cv = (c == 2) ? 2'b11 : (c == 1) ? (($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10) : 2'b00;
         f  = ($urandom_range(0, 15) == 0);
         k0 = $urandom_range(0, 31);
         k1 = (k0 + 1 + $urandom_range(0, 30)) % 32;
         cyc(v, cv, m_map[k0], m_map[k1], f);
         if (n % 25 == 24) check_idle(32 - m_ns, m_all[m_ns % 32]);
      end
      check_idle(32 - m_ns, m_all[m_ns % 32]);

      @(posedge clk);
      #1 chk = 1'b0;
      free_list_valid = 2'b00;
      commit_valid    = 2'b00;
      flush           = 1'b0;
      repeat (2) @(posedge clk);
      cmp("grant_queue_drained", g_q.size(), 0);
      cmp("status_queue_drained", st_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 Parameter PHY_REGS, default 64, number of physical registers.
REQ-002 Parameter ARCH_REGS, default 32, number of architectural registers.
REQ-003 Parameter PHY_WIDTH, default 6, physical register index width (log2 PHY_REGS).
REQ-004 Parameter FL_DEPTH, default PHY_REGS-ARCH_REGS (32), free-list capacity.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  asynchronous active-low reset.
REQ-008 flush  in  1  mispredict recovery; roll speculative state back to committed state.
REQ-009 free_list_valid  in  2  per-slot allocation request from Rename (slot 0 older).
REQ-010 rd_phy_new_0  out  PHY_WIDTH  register granted to slot 0.
REQ-011 rd_phy_new_1  out  PHY_WIDTH  register granted to slot 1.
REQ-012 commit_valid  in  2  per-slot retirement of an instruction that allocated a register.
REQ-013 commit_phy_old_0  in  PHY_WIDTH  stale mapping freed by commit slot 0.
REQ-014 commit_phy_old_1  in  PHY_WIDTH  stale mapping freed by commit slot 1.
REQ-015 free_count  out  PHY_WIDTH  speculative free registers, head to tail.
REQ-016 free_list_stall  out  1  high when free_count < 2; feeds stall_dispatch.

Function
REQ-017 Storage: circular FIFO of FL_DEPTH entries; pointers spec_head, commit_head, tail, each log2(FL_DEPTH)+1 bits, wrap bit included.
REQ-018 free_count = tail - spec_head (modular); FIFO is empty when tail and spec_head are equal including the wrap bit.
REQ-019 Read-ahead, combinational: rd_phy_new_0 = fifo[spec_head]; rd_phy_new_1 = fifo[spec_head+1] if free_list_valid[0], else fifo[spec_head].
REQ-020 Allocate: on the clock edge with flush low, spec_head advances by popcount(free_list_valid), value 0, 1 or 2.
REQ-021 Requesting more registers than free_count is a protocol violation; the block SHALL NOT advance spec_head past tail.
REQ-022 Release: each clock edge, valid commit slots write commit_phy_old_x at tail in slot order, 0 then 1. Tail advances by popcount(commit_valid). If only slot 1 is valid, it writes at tail.
REQ-023 commit_head advances by popcount(commit_valid) each clock edge, because allocation and release pair one-to-one per committed rename.
REQ-024 Flush: spec_head <= commit_head + popcount(commit_valid) for the same cycle. Allocation that cycle is ignored. Same-cycle release still applies.
REQ-025 Allocation and release in the same cycle SHALL both take effect; free_count_next = free_count - alloc + release.
REQ-026 All pointer arithmetic wraps modulo 2*FL_DEPTH. Entry index = pointer[log2(FL_DEPTH)-1:0].
REQ-027 free_list_stall is combinational from free_count.

Reset
REQ-028 On rst low, asynchronously: fifo[i] = ARCH_REGS+i for i = 0..FL_DEPTH-1; spec_head = 0; commit_head = 0; tail = FL_DEPTH with the wrap bit set.
REQ-029 Outputs after reset: free_count = 32, free_list_stall = 0, rd_phy_new_0 = 32, rd_phy_new_1 = 32 when free_list_valid = 00.
REQ-030 Reset mid-operation discards all speculative and committed pointer state with no residue.

Structure
REQ-031 PHY_REGS, ARCH_REGS, PHY_WIDTH and FL_DEPTH defaults SHALL live in parameter_pkg. No new typedefs are needed in typedef_pkg.
REQ-032 Single flat module, no sub-modules; a popcount2 helper function is local to the module.

Verification
REQ-033 Reset then free_list_valid=11 for one cycle -> grants 32 and 33; next cycle free_count = 30 and rd_phy_new_0 = 34.
REQ-034 Allocate 15 cycles x 2 -> free_count = 2, stall = 0; allocate 11 once more -> free_count = 0, stall = 1.
REQ-035 Allocate 4 (p32..p35), commit_valid=01 with old=5, then flush -> spec_head = commit_head; rd_phy_new_0 = 33; free_count = 32.
REQ-036 free_list_valid=10 -> rd_phy_new_1 = fifo[spec_head] (32), and spec_head advances by 1.
REQ-037 Simultaneous alloc 11, commit 11 (old 7, 9), flush 0 -> free_count unchanged; 7 and 9 are at the old tail slots.
REQ-038 Fill-and-drain for 3 full wraps with random legal alloc/commit/flush against a reference model -> grant sequence matches; no register is duplicated in flight.
